vga_scan_ctrl: RTL and testbench

- Scan-out controller for the VGA frame buffer.
- Generates 640x480 raster timing and fetches one 32-bit pixel word per active pixel from the frame-buffer read port through a req/ack handshake.
- Buffers fetched words in a small prefetch FIFO and drives the vga_r/g/b, hsync, vsync and valid pins.
- Sits between the frame buffer (written over APB by the CPU) and the board VGA pins.

---
 rtl/vga_scan_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_vga_scan_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl: 640x480 raster timing with prefetching frame-buffer scan-out (rev 1.0).
// Optional build macro VGA_SCAN_UNDERFLOW_CNT_EN adds the saturating underflow_cnt output.
`default_nettype none

module vga_scan_ctrl #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int ADDR_W     = 21,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  output logic              fb_req,
  output logic [ADDR_W-1:0] fb_addr,
  input  logic              fb_ack,
  input  logic [31:0]       fb_rdata,
  output logic [7:0]        vga_r,
  output logic [7:0]        vga_g,
  output logic [7:0]        vga_b,
  output logic              vga_hsync,
  output logic              vga_vsync,
  output logic              vga_valid,
  output logic              underflow
`ifdef VGA_SCAN_UNDERFLOW_CNT_EN
  ,
  output logic [15:0]       underflow_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int PW      = $clog2(FIFO_DEPTH);
  localparam int CW      = PW + 1;

  localparam logic [HW-1:0]     H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]     H_ACT     = HW'(H_ACTIVE);
  localparam logic [HW-1:0]     HS_BEG    = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0]     HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0]     V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]     V_ACT     = VW'(V_ACTIVE);
  localparam logic [VW-1:0]     VS_BEG    = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0]     VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
  localparam logic [CW-1:0]     DEPTH     = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic [23:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nx;
  logic          discard, desynced;
  logic          running, active, hs_win, vs_win, fifo_empty;
  logic          pop, starve, resync, flush, ack_take, push, req_nx;
  logic          unused_rdata;

  assign unused_rdata = ^fb_rdata[31:24];

  always_comb begin
    state_nx = state;
    case (state)
      ST_OFF:   if (enable) state_nx = ST_PRIME;
      ST_PRIME: if (!enable) state_nx = ST_OFF;
                else if (count == DEPTH) state_nx = ST_RUN;
      ST_RUN:   if (!enable) state_nx = ST_OFF;
      default:  state_nx = ST_OFF;
    endcase
  end

  assign running    = (state == ST_RUN) && enable;
  assign active     = (hcnt < H_ACT) && (vcnt < V_ACT);
  assign hs_win     = (hcnt >= HS_BEG) && (hcnt < HS_END);
  assign vs_win     = (vcnt >= VS_BEG) && (vcnt < VS_END);
  assign fifo_empty = (count == '0);
  assign pop        = running && active && !fifo_empty;
  assign starve     = running && active && fifo_empty;
  assign resync     = running && desynced && (hcnt == '0) && (vcnt == V_ACT);
  assign flush      = (state == ST_OFF) || resync;
  assign ack_take   = fb_req && fb_ack;
  // Data returned for a request issued before a flush belongs to the old stream.
  assign push       = ack_take && !discard && !flush;

  always_comb begin
    count_nx = count;
    if (flush)              count_nx = '0;
    else if (push && !pop)  count_nx = count + 1'b1;
    else if (pop && !push)  count_nx = count - 1'b1;
  end

  // One request in flight: after an ack the outstanding term is zero, so count_nx alone gates reissue.
  assign req_nx = (fb_req && !fb_ack) ? 1'b1
                                      : ((state_nx != ST_OFF) && (count_nx < DEPTH));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_OFF;
    else       state <= state_nx;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (state != ST_RUN) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fb_req  <= 1'b0;
      fb_addr <= '0;
      discard <= 1'b0;
    end else begin
      fb_req <= req_nx;
      if (ack_take) begin
        discard <= 1'b0;
        if (discard || flush) fb_addr <= '0;
        else                  fb_addr <= (fb_addr == ADDR_LAST) ? '0 : fb_addr + 1'b1;
      end else if (flush) begin
        // Address must stay put under a pending request; it restarts when that ack lands.
        if (fb_req) discard <= 1'b1;
        else        fb_addr <= '0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_nx;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= fb_rdata[23:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      desynced  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (starve) underflow <= 1'b1;
      if (state == ST_OFF || resync) desynced <= 1'b0;
      else if (starve)               desynced <= 1'b1;
    end
  end

`ifdef VGA_SCAN_UNDERFLOW_CNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                   underflow_cnt <= '0;
    else if (starve && underflow_cnt != 16'hFFFF) underflow_cnt <= underflow_cnt + 1'b1;
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      {vga_r, vga_g, vga_b} <= '0;
      vga_hsync             <= 1'b1;
      vga_vsync             <= 1'b1;
      vga_valid             <= 1'b0;
    end else if (running) begin
      {vga_r, vga_g, vga_b} <= pop ? mem[rd_ptr] : 24'h0;
      vga_hsync             <= ~hs_win;
      vga_vsync             <= ~vs_win;
      vga_valid             <= active;
    end else begin
      {vga_r, vga_g, vga_b} <= '0;
      vga_hsync             <= 1'b1;
      vga_vsync             <= 1'b1;
      vga_valid             <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_scan_ctrl.sv
// tb_vga_scan_ctrl: bench for vga_scan_ctrl on a reduced 8x5 (40-clock) raster.
`default_nettype none

module tb_vga_scan_ctrl;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        fb_req;
  logic [20:0] fb_addr;
  logic        fb_ack;
  logic [31:0] fb_rdata;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        vga_hsync, vga_vsync, vga_valid, underflow;
`ifdef VGA_SCAN_UNDERFLOW_CNT_EN
  logic [15:0] underflow_cnt;
`endif

  vga_scan_ctrl #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .ADDR_W(21), .FIFO_DEPTH(4)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .fb_req(fb_req), .fb_addr(fb_addr), .fb_ack(fb_ack), .fb_rdata(fb_rdata),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_valid(vga_valid),
    .underflow(underflow)
`ifdef VGA_SCAN_UNDERFLOW_CNT_EN
    , .underflow_cnt(underflow_cnt)
`endif
  );

  typedef struct {
    int          hpos;
    int          vpos;
    logic        valid;
    logic        hsync;
    logic        vsync;
    logic [23:0] rgb;
  } vec_t;

  vec_t        tbl [40];
  logic [23:0] sb [$];
  int          tests = 0;
  int          fails = 0;
  int          ack_delay = 0;
  int          wait_cnt = 0;
  int          ack_count = 0;
  int          exp_addr = 0;
  logic        sb_on = 1'b1;
  logic        addr_chk = 1'b1;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_idle(input string name);
    check({name, "_rgb"}, 32'({vga_r, vga_g, vga_b}), 32'h0);
    check({name, "_hsync"}, 32'(vga_hsync), 32'h1);
    check({name, "_vsync"}, 32'(vga_vsync), 32'h1);
    check({name, "_valid"}, 32'(vga_valid), 32'h0);
  endtask

  // Collects the next eight visible pixels and expects words 0..7 in order.
  task automatic expect_frame(input string name);
    int got = 0;
    for (int i = 0; i < 150 && got < 8; i++) begin
      if (vga_valid) begin
        check(name, 32'({vga_r, vga_g, vga_b}), 32'(got));
        got++;
      end
      step();
    end
    if (got < 8) check({name, "_timeout"}, 32'(got), 32'd8);
  endtask

  // Frame-buffer responder: acks after ack_delay waiting cycles, returns rdata = address.
  always @(negedge clock) begin
    if (reset) begin
      fb_ack   = 1'b0;
      wait_cnt = 0;
    end else begin
      if (fb_ack) begin
        fb_ack   = 1'b0;
        wait_cnt = 0;
      end
      if (fb_req) begin
        if (wait_cnt >= ack_delay) begin
          fb_ack   = 1'b1;
          fb_rdata = 32'(fb_addr);
          ack_count++;
          if (addr_chk) begin
            check("fetch_addr", 32'(fb_addr), 32'(exp_addr));
            exp_addr = (exp_addr == 7) ? 0 : exp_addr + 1;
          end
          if (sb_on) sb.push_back(fb_rdata[23:0]);
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  initial begin
    int          edges;
    int          idx;
    int          snap;
    logic [20:0] held_addr;
    logic [23:0] want;

    reset    = 1'b1;
    enable   = 1'b0;
    fb_ack   = 1'b0;
    fb_rdata = 32'h0;

    for (int v = 0; v < 5; v++) begin
      for (int h = 0; h < 8; h++) begin
        idx            = v * 8 + h;
        tbl[idx].hpos  = h;
        tbl[idx].vpos  = v;
        tbl[idx].valid = (v < 2) && (h < 4);
        tbl[idx].hsync = !(h == 5 || h == 6);
        tbl[idx].vsync = (v != 3);
        tbl[idx].rgb   = tbl[idx].valid ? 24'(v * 4 + h) : 24'h0;
      end
    end

    repeat (3) step();
    check_idle("reset");
    check("reset_underflow", 32'(underflow), 32'h0);
    check("reset_req", 32'(fb_req), 32'h0);
    check("reset_addr", 32'(fb_addr), 32'h0);
`ifdef VGA_SCAN_UNDERFLOW_CNT_EN
    check("reset_ucnt", 32'(underflow_cnt), 32'h0);
`endif
    @(negedge clock) reset = 1'b0;
    step();
    check_idle("off");

    // Normal scan: four prefetches, then three frames against the timing table.
    enable = 1'b1;
    edges  = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      edges++;
      if (vga_valid) break;
    end
    check("prime_latency", 32'(edges), 32'd7);
    for (int k = 0; k < 120; k++) begin
      idx = k % 40;
      check("tbl_valid", 32'(vga_valid), 32'(tbl[idx].valid));
      check("tbl_hsync", 32'(vga_hsync), 32'(tbl[idx].hsync));
      check("tbl_vsync", 32'(vga_vsync), 32'(tbl[idx].vsync));
      check("tbl_rgb", 32'({vga_r, vga_g, vga_b}), 32'(tbl[idx].rgb));
      check("tbl_underflow", 32'(underflow), 32'h0);
      if (tbl[idx].valid) begin
        if (sb.size() == 0) begin
          check("sb_empty", 32'h1, 32'h0);
        end else begin
          want = sb.pop_front();
          check("sb_pixel", 32'({vga_r, vga_g, vga_b}), 32'(want));
        end
      end
      step();
    end

    // Slow frame buffer: starvation, then recovery on the following frame.
    sb_on     = 1'b0;
    addr_chk  = 1'b0;
    ack_delay = 3;
    for (int i = 0; i < 200; i++) begin
      if (underflow) break;
      step();
    end
    check("underflow_set", 32'(underflow), 32'h1);
    check("starve_valid", 32'(vga_valid), 32'h1);
    check("starve_black", 32'({vga_r, vga_g, vga_b}), 32'h0);
`ifdef VGA_SCAN_UNDERFLOW_CNT_EN
    check("ucnt_nonzero", 32'(underflow_cnt != 16'h0), 32'h1);
`endif
    ack_delay = 0;
    for (int i = 0; i < 60 && vga_vsync; i++) step();
    check("wait_vsync_low", 32'(vga_vsync), 32'h0);
    for (int i = 0; i < 20 && !vga_vsync; i++) step();
    check("wait_vsync_high", 32'(vga_vsync), 32'h1);
    expect_frame("resync_pixel");
    check("underflow_sticky", 32'(underflow), 32'h1);

    // Disable mid-line with a request held open.
    ack_delay = 1000;
    for (int i = 0; i < 100; i++) begin
      if (vga_valid && fb_req) break;
      step();
    end
    check("pre_off_req", 32'(fb_req & vga_valid), 32'h1);
    enable = 1'b0;
    step();
    check_idle("disable");
    check("disable_req_held", 32'(fb_req), 32'h1);
    held_addr = fb_addr;
    repeat (4) step();
    check("off_req_held", 32'(fb_req), 32'h1);
    check("off_addr_stable", 32'(fb_addr), 32'(held_addr));
    snap      = ack_count;
    ack_delay = 0;
    for (int i = 0; i < 20 && ack_count == snap; i++) step();
    check("discard_ack_seen", 32'(ack_count - snap), 32'h1);
    step();
    step();
    check("off_req_drop", 32'(fb_req), 32'h0);
    check("off_addr_zero", 32'(fb_addr), 32'h0);
    check_idle("off2");
    exp_addr = 0;
    addr_chk = 1'b1;
    enable   = 1'b1;
    expect_frame("restart_pixel");

    // Asynchronous reset between clock edges.
    repeat (5) step();
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    check_idle("async_reset");
    check("async_underflow", 32'(underflow), 32'h0);
    check("async_req", 32'(fb_req), 32'h0);
    check("async_addr", 32'(fb_addr), 32'h0);
`ifdef VGA_SCAN_UNDERFLOW_CNT_EN
    check("async_ucnt", 32'(underflow_cnt), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
